pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and generates pc_plus4, which drives inp1 of the 32-bit next-PC select mux.
- Consumes that mux's output (next_pc) together with its select (redirect).
- Runs the req/ack handshake to instruction memory and loads the IF/ID pipeline register under stall/redirect control from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  32  next PC from the PC-select mux.
- redirect  input  1  PC-select mux sel. 1 = branch/jump taken: load next_pc and flush.
- stall  input  1  hazard unit: hold IF/ID and PC.
- pc  output  32  current fetch PC.
- pc_plus4  output  32  pc + 4, combinational, to mux inp1.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address, stable while imem_req=1 until ack.
- imem_ack  input  1  memory returns imem_rdata this cycle; may arrive in the same cycle as req.
- imem_rdata  input  32  instruction word.
- if_id_valid  output  1  IF/ID register holds a valid instruction.
- if_id_instr  output  32  fetched instruction.
- if_id_pc_plus4  output  32  address of fetched instruction + 4.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, if_id_valid=0.
  - if_id_instr=0, if_id_pc_plus4=0, skid register cleared.
  - imem_req=0 while rst_n=0.
  - imem_addr=RESET_PC.
- Reset deassertion mid-transaction: any pending ack is the requester's loss. Memory is reset from the same rst_n.
- pc_plus4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- req_addr register: captured from pc when a new request starts; drives imem_addr.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1.
  - ack=1, stall=0, redirect=0:
    - IF/ID <= {valid=1, instr=imem_rdata, pc_plus4=req_addr+4}.
    - pc <= next_pc; new request at next_pc in the next cycle.
    - Stay in FETCH.
  - ack=1, stall=1, redirect=0: imem_rdata and req_addr+4 go into the skid register; IF/ID and pc unchanged; -> HOLD.
  - ack=0: wait, pc unchanged.
  - Zero-wait memory (ack every cycle): one instruction per cycle. Latency req->if_id_valid = 1 cycle after ack.
- HOLD:
  - imem_req=0.
  - stall=0: IF/ID <= skid (valid=1); pc <= next_pc; -> FETCH.
  - stall=1: remain.
- redirect=1 (priority over stall and ack):
  - pc <= next_pc, if_id_valid <= 0, skid cleared.
  - From FETCH with ack=0: request outstanding -> DRAIN.
  - From FETCH with ack=1, or from HOLD: -> FETCH; returned data discarded.
- DRAIN:
  - imem_req=1, imem_addr=old req_addr (stable until ack).
  - On ack: data discarded; -> FETCH; next request uses pc.
  - Further redirect in DRAIN: pc updated again, remain in DRAIN.
- stall=1 in FETCH with no ack: no effect until ack arrives. IF/ID holds its contents whenever stall=1.
- if_id_valid is never asserted for data returned after a redirect.
- pc changes only on accepted instruction or redirect.

Test Plan:
- Reset, zero-wait memory returning instr = addr ^ 32'hA5A5_A5A5, next_pc=pc_plus4 -> pc sequence 0,4,8,12; if_id_valid=1 from 2nd cycle after rst_n rises; if_id_pc_plus4 = 4,8,12.
- Stall for 3 cycles coinciding with ack at pc=8 -> HOLD; imem_req=0 for the stall; IF/ID keeps the pc=4 instruction; after release IF/ID gets instr@8, pc=12; no instruction lost or duplicated.
- Redirect with next_pc=32'h0000_0100 while a 3-cycle-latency request to 32'h10 is outstanding -> DRAIN; imem_addr stays 32'h10 until ack; that data is discarded; next request addr=32'h100; if_id_valid=0 in between.
- Redirect and stall asserted in the same cycle as an ack -> if_id_valid=0, pc=next_pc, state FETCH; the acked word never appears on if_id_instr.
- pc=32'hFFFF_FFFC -> pc_plus4=0; with sequential next_pc, fetch wraps to address 0.
- Assert rst_n=0 asynchronously mid-HOLD -> outputs immediately at reset values, imem_req=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch stage of the MIPS pipeline.
// Owns the PC, issues req/ack fetches to instruction memory and loads the
// IF/ID pipeline register under stall/redirect control from the hazard unit.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   next_pc          next PC from the PC-select mux
//   redirect         PC-select mux sel: load next_pc and flush
//   stall            hazard unit: hold IF/ID and PC
//   pc               current fetch PC
//   pc_plus4         pc + 4 (combinational), to mux inp1
//   imem_req         instruction memory request
//   imem_addr        request address, stable while imem_req=1 until ack
//   imem_ack         memory returns imem_rdata this cycle
//   imem_rdata       instruction word
//   if_id_valid      IF/ID register holds a valid instruction
//   if_id_instr      fetched instruction
//   if_id_pc_plus4   address of fetched instruction + 4
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic            ack_eff;

    // An ack only counts against a request actually on the bus; a stray ack
    // in the first cycle after reset is dropped.
    assign ack_eff = imem_ack & imem_req_q;

    // Next-state, PC, skid and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d         = next_pc;
                    if_valid_d   = 1'b0;
                    skid_instr_d = '0;
                    skid_pc4_d   = '0;
                    // An unanswered request must be drained before refetching.
                    state_d      = (imem_req_q && !imem_ack) ? DRAIN : FETCH;
                end else if (ack_eff) begin
                    if (stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = req_addr_q + XLEN'(4);
                        state_d      = HOLD;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc4_d   = req_addr_q + XLEN'(4);
                        pc_d       = next_pc;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = next_pc;
                    if_valid_d   = 1'b0;
                    skid_instr_d = '0;
                    skid_pc4_d   = '0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_instr_d = skid_instr_q;
                    if_pc4_d   = skid_pc4_q;
                    pc_d       = next_pc;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d         = next_pc;
                    skid_instr_d = '0;
                    skid_pc4_d   = '0;
                end
                if (redirect || !stall) begin
                    if_valid_d = 1'b0;
                end
                if (ack_eff) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Request address follows pc whenever fetching, frozen while draining.
    always_comb begin
        req_addr_d = (state_d == FETCH) ? pc_d : req_addr_q;
        imem_req_d = (state_d != HOLD);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            imem_req_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc4_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            imem_req_q   <= imem_req_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign imem_req       = imem_req_q;
    assign imem_addr      = req_addr_q;
    assign if_id_valid    = if_valid_q;
    assign if_id_instr    = if_instr_q;
    assign if_id_pc_plus4 = if_pc4_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_pc_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;

    int passed = 0;
    int total  = 0;

    // Reference model: fetch PC, request on bus (address, stale flag),
    // instruction parked by a stall, and the IF/ID contents.
    logic [31:0] m_pc, m_req_addr, m_held_instr, m_held_pc4, m_instr, m_pc4;
    logic        m_req_on, m_stale, m_held, m_valid;

    // Memory: acks a request once it has waited mem_lat cycles.
    int mem_cnt = 0;
    int mem_lat = 0;
    bit mem_rand = 1'b0;

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect),
        .stall(stall), .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0; m_req_addr = 32'h0; m_req_on = 1'b0; m_stale = 1'b0;
        m_held = 1'b0; m_held_instr = 32'h0; m_held_pc4 = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        mem_cnt = 0;
    endtask

    // Drive one cycle of stimulus (from a negedge), advance the model and
    // the memory, and return at the following negedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        logic ack_ok;
        logic outstanding;
        stall      = st;
        redirect   = rd;
        next_pc    = rd ? tgt : m_pc + 32'd4;
        imem_ack   = imem_req && (mem_cnt >= mem_lat);
        imem_rdata = imem_ack ? (imem_addr ^ K) : 32'hDEAD_BEEF;
        ack_ok      = imem_ack && m_req_on;
        outstanding = m_req_on && !ack_ok;
        if (rd) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            m_held  = 1'b0;
            if (outstanding) m_stale = 1'b1;
            else begin m_stale = 1'b0; m_req_addr = m_pc; m_req_on = 1'b1; end
        end else if (m_stale) begin
            if (!st) m_valid = 1'b0;
            if (ack_ok) begin m_stale = 1'b0; m_req_addr = m_pc; end
        end else if (m_held) begin
            if (!st) begin
                m_valid = 1'b1; m_instr = m_held_instr; m_pc4 = m_held_pc4;
                m_held = 1'b0; m_pc = next_pc; m_req_addr = m_pc; m_req_on = 1'b1;
            end
        end else begin
            if (ack_ok && !st) begin
                m_valid = 1'b1; m_instr = m_req_addr ^ K; m_pc4 = m_req_addr + 32'd4;
                m_pc = next_pc; m_req_addr = m_pc; m_req_on = 1'b1;
            end else if (ack_ok && st) begin
                m_held = 1'b1; m_held_instr = m_req_addr ^ K;
                m_held_pc4 = m_req_addr + 32'd4; m_req_on = 1'b0;
            end else begin
                if (!st) m_valid = 1'b0;
                m_req_on = 1'b1;
            end
        end
        if (imem_ack) begin
            mem_cnt = 0;
            if (mem_rand) mem_lat = $urandom_range(0, 3);
        end else if (imem_req) begin
            mem_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; next_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge clk); @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; next_pc = 32'h0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #3;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
        @(negedge clk); @(negedge clk);
        total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else passed++;
        total++; if (pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req2 got %b want 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
        total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else passed++;
        total++; if (if_id_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", if_id_instr); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL reset_ifpc4 got %h want 0", if_id_pc_plus4); else passed++;
        imem_ack = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Zero-wait memory: pc 0,4,8,12 and IF/ID valid from the 2nd cycle.
    task automatic test_sequential();
        mem_rand = 1'b0; mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            total++; if (pc !== 32'(i * 4)) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(i * 4)); else passed++;
            total++; if (if_id_valid !== (i >= 1)) $display("FAIL seq_valid[%0d] got %b want %b", i, if_id_valid, (i >= 1)); else passed++;
            if (i >= 1) begin
                total++; if (if_id_pc_plus4 !== 32'(i * 4)) $display("FAIL seq_ifpc4[%0d] got %h want %h", i, if_id_pc_plus4, 32'(i * 4)); else passed++;
                total++; if (if_id_instr !== (32'((i - 1) * 4) ^ K)) $display("FAIL seq_instr[%0d] got %h want %h", i, if_id_instr, 32'((i - 1) * 4) ^ K); else passed++;
            end
        end
    endtask

    // Three-cycle stall coinciding with the ack for pc=8.
    task automatic test_stall();
        do_reset();
        mem_rand = 1'b0; mem_lat = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); else passed++;
            total++; if (pc !== 32'h8) $display("FAIL stall_pc[%0d] got %h want 8", i, pc); else passed++;
            total++; if (if_id_pc_plus4 !== 32'h8 || if_id_instr !== (32'h4 ^ K)) $display("FAIL stall_ifid[%0d] got %h/%h want 8/%h", i, if_id_pc_plus4, if_id_instr, 32'h4 ^ K); else passed++;
        end
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (if_id_instr !== (32'h8 ^ K) || if_id_valid !== 1'b1) $display("FAIL unstall_instr got %h v%b want %h v1", if_id_instr, if_id_valid, 32'h8 ^ K); else passed++;
        total++; if (pc !== 32'hC || imem_req !== 1'b1) $display("FAIL unstall_pc got %h req%b want c req1", pc, imem_req); else passed++;
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (if_id_pc_plus4 !== 32'h10) $display("FAIL unstall_next got %h want 10", if_id_pc_plus4); else passed++;
    endtask

    // Redirect to 0x100 while a 3-cycle request to 0x10 is outstanding.
    task automatic test_redirect_drain();
        do_reset();
        mem_rand = 1'b0; mem_lat = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
        total++; if (pc !== 32'h10) $display("FAIL drain_pre_pc got %h want 10", pc); else passed++;
        mem_lat = 3;
        cycle(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) $display("FAIL drain_addr[%0d] got %h req%b want 10 req1", i, imem_addr, imem_req); else passed++;
            total++; if (if_id_valid !== 1'b0) $display("FAIL drain_valid[%0d] got %b want 0", i, if_id_valid); else passed++;
            total++; if (pc !== 32'h100) $display("FAIL drain_pc[%0d] got %h want 100", i, pc); else passed++;
            cycle(1'b0, 1'b0, 32'h0);
        end
        total++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) $display("FAIL drain_done got %h v%b want 100 v0", imem_addr, if_id_valid); else passed++;
        mem_lat = 0;
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (if_id_instr !== (32'h100 ^ K) || if_id_pc_plus4 !== 32'h104) $display("FAIL drain_first got %h/%h want %h/104", if_id_instr, if_id_pc_plus4, 32'h100 ^ K); else passed++;
    endtask

    // Redirect and stall in the same cycle as an ack.
    task automatic test_redirect_stall_ack();
        do_reset();
        mem_rand = 1'b0; mem_lat = 0;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        total++; if (if_id_valid !== 1'b0) $display("FAIL rsa_valid got %b want 0", if_id_valid); else passed++;
        total++; if (pc !== 32'h40 || imem_addr !== 32'h40 || imem_req !== 1'b1) $display("FAIL rsa_pc got %h/%h req%b want 40/40 req1", pc, imem_addr, imem_req); else passed++;
        total++; if (if_id_instr === (32'h4 ^ K)) $display("FAIL rsa_leak got %h want not %h", if_id_instr, 32'h4 ^ K); else passed++;
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (if_id_instr !== (32'h40 ^ K) || if_id_valid !== 1'b1) $display("FAIL rsa_next got %h v%b want %h v1", if_id_instr, if_id_valid, 32'h40 ^ K); else passed++;
    endtask

    // PC wraps from 0xFFFF_FFFC to 0.
    task automatic test_wrap();
        do_reset();
        mem_rand = 1'b0; mem_lat = 0;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) $display("FAIL wrap_pc got %h/%h want fffffffc/0", pc, pc_plus4); else passed++;
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (pc !== 32'h0 || imem_addr !== 32'h0) $display("FAIL wrap_next got %h/%h want 0/0", pc, imem_addr); else passed++;
        total++; if (if_id_pc_plus4 !== 32'h0 || if_id_instr !== (32'hFFFF_FFFC ^ K)) $display("FAIL wrap_ifid got %h/%h want 0/%h", if_id_pc_plus4, if_id_instr, 32'hFFFF_FFFC ^ K); else passed++;
    endtask

    // Asynchronous reset asserted mid-HOLD.
    task automatic test_async_reset();
        do_reset();
        mem_rand = 1'b0; mem_lat = 0;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        total++; if (imem_req !== 1'b0 || pc !== 32'h4) $display("FAIL ares_hold got req%b pc %h want req0 pc 4", imem_req, pc); else passed++;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) $display("FAIL ares_now got req%b %h/%h want req0 0/0", imem_req, pc, imem_addr); else passed++;
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0) $display("FAIL ares_ifid got v%b %h/%h want v0 0/0", if_id_valid, if_id_instr, if_id_pc_plus4); else passed++;
        @(negedge clk);
        stall = 1'b0;
        model_reset();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        total++; if (pc !== 32'h4 || if_id_instr !== (32'h0 ^ K) || if_id_pc_plus4 !== 32'h4) $display("FAIL ares_restart got %h/%h/%h want 4/%h/4", pc, if_id_instr, if_id_pc_plus4, K); else passed++;
    endtask

    // Randomized stall/redirect/latency against the reference model.
    task automatic test_back_to_back();
        logic [31:0] tgt;
        logic st, rd;
        do_reset();
        mem_rand = 1'b1; mem_lat = 0;
        for (int i = 0; i < 800; i++) begin
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle(st, rd, tgt);
            total++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_pc[%0d] got %h/%h want %h/%h", i, pc, pc_plus4, m_pc, m_pc + 32'd4); else passed++;
            total++; if (imem_req !== m_req_on || imem_addr !== m_req_addr) $display("FAIL rnd_req[%0d] got %b/%h want %b/%h", i, imem_req, imem_addr, m_req_on, m_req_addr); else passed++;
            total++; if (if_id_valid !== m_valid || if_id_instr !== m_instr || if_id_pc_plus4 !== m_pc4) $display("FAIL rnd_ifid[%0d] got %b/%h/%h want %b/%h/%h", i, if_id_valid, if_id_instr, if_id_pc_plus4, m_valid, m_instr, m_pc4); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_stall_ack();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
